// File: rtl/tcdm_fill_check_pkg.sv
// Shared types and helpers for the TCDM fill-and-check engine.
//   state_e      : engine FSM states
//   BE_ALL       : byte enables used on every request (full-word accesses only)
//   fill_pattern : data word written at a given byte address for a given seed
package tcdm_fill_check_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWdrain,
    StRead,
    StRdrain,
    StDone
  } state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic [31:0] fill_pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/tcdm_outstanding_cnt.sv
// Up/down counter of granted TCDM requests still waiting for r_valid.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : a request was granted this cycle
//   dec_i         : a response arrived this cycle
//   full_o        : count == MAX_OUTSTANDING
//   empty_o       : count == 0
module tcdm_outstanding_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dec_ok;

  // Stray responses after a mid-operation reset must not underflow the count.
  assign dec_ok = dec_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_ok) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!inc_i && dec_ok) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == MaxCnt);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/tcdm_fill_check.sv
// TCDM initiator that fills a contiguous word range with an address-derived
// pattern, reads it back in order and counts mismatching responses.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : start strobe (ignored while busy)
//   base_addr_i            : first byte address (word aligned internally)
//   num_words_i            : number of words to fill and check
//   seed_i                 : pattern seed, data = addr ^ seed
//   busy_o, done_o         : operation in progress / one-cycle completion pulse
//   pass_o                 : last run saw zero errors
//   err_cnt_o              : saturating mismatch count of last run
//   first_err_addr_o       : byte address of the first mismatch
//   tcdm_*                 : XBAR_TCDM_BUS initiator signals
module tcdm_fill_check
  import tcdm_fill_check_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] num_words_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [31:0]          first_err_addr_o,
  output logic                 tcdm_req_o,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [31:0]          tcdm_wdata_o,
  output logic [3:0]           tcdm_be_o,
  input  logic                 tcdm_gnt_i,
  input  logic                 tcdm_r_valid_i,
  input  logic [31:0]          tcdm_r_rdata_i,
  input  logic                 tcdm_r_opc_i
);

  state_e               state_q;
  logic [31:0]          base_q, seed_q;
  logic [CNT_WIDTH-1:0] num_q, issue_idx_q, rsp_idx_q, err_cnt_q;
  logic [31:0]          add_q, wdata_q, rsp_addr_q, first_err_q;
  logic                 wen_q, pass_q;

  logic                 out_full, out_empty;
  logic                 issuing, grant, last_issue, rsp_chk, rsp_err;
  logic [31:0]          base_al;
  logic [CNT_WIDTH-1:0] last_idx;

  assign base_al  = base_addr_i & 32'hFFFF_FFFC;
  assign last_idx = num_q - CNT_WIDTH'(1);

  // req depends only on flops, so it cannot drop while a request waits for
  // gnt: the outstanding count can only fall until that request is granted.
  assign issuing    = (state_q == StWrite) || (state_q == StRead);
  assign tcdm_req_o = issuing && !out_full;
  assign grant      = tcdm_req_o && tcdm_gnt_i;
  assign last_issue = (issue_idx_q == last_idx);

  // Write responses drain in StWdrain, so every r_valid seen here is a read.
  assign rsp_chk = tcdm_r_valid_i && ((state_q == StRead) || (state_q == StRdrain));
  assign rsp_err = tcdm_r_opc_i || (tcdm_r_rdata_i != fill_pattern(rsp_addr_q, seed_q));

  tcdm_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (grant),
    .dec_i  (tcdm_r_valid_i),
    .full_o (out_full),
    .empty_o(out_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= '0;
      seed_q      <= '0;
      num_q       <= '0;
      issue_idx_q <= '0;
      rsp_idx_q   <= '0;
      rsp_addr_q  <= '0;
      add_q       <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b1;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            if (num_words_i == '0) begin
              pass_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              base_q      <= base_al;
              seed_q      <= seed_i;
              num_q       <= num_words_i;
              issue_idx_q <= '0;
              add_q       <= base_al;
              wdata_q     <= fill_pattern(base_al, seed_i);
              wen_q       <= 1'b0;
              state_q     <= StWrite;
            end
          end
        end
        StWrite: begin
          if (grant) begin
            issue_idx_q <= issue_idx_q + CNT_WIDTH'(1);
            add_q       <= add_q + 32'd4;
            wdata_q     <= fill_pattern(add_q + 32'd4, seed_q);
            if (last_issue) begin
              state_q <= StWdrain;
            end
          end
        end
        StWdrain: begin
          if (out_empty) begin
            issue_idx_q <= '0;
            add_q       <= base_q;
            wen_q       <= 1'b1;
            rsp_idx_q   <= '0;
            rsp_addr_q  <= base_q;
            state_q     <= StRead;
          end
        end
        StRead: begin
          if (grant) begin
            issue_idx_q <= issue_idx_q + CNT_WIDTH'(1);
            add_q       <= add_q + 32'd4;
            if (last_issue) begin
              state_q <= StRdrain;
            end
          end
        end
        StRdrain: begin
          // err_cnt_q is final once every response has been counted.
          if (rsp_idx_q == num_q) begin
            pass_q  <= (err_cnt_q == '0);
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (rsp_chk) begin
        rsp_idx_q  <= rsp_idx_q + CNT_WIDTH'(1);
        rsp_addr_q <= rsp_addr_q + 32'd4;
        if (rsp_err) begin
          if (err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
          end
          if (err_cnt_q == '0) begin
            first_err_q <= rsp_addr_q;
          end
        end
      end
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign tcdm_add_o       = add_q;
  assign tcdm_wen_o       = wen_q;
  assign tcdm_wdata_o     = wdata_q;
  assign tcdm_be_o        = BE_ALL;

endmodule

// File: tb/tb_tcdm_fill_check.sv
module tb_tcdm_fill_check;

  localparam int unsigned MaxOut = 2;
  localparam int unsigned CntW   = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [31:0]     base_addr_i = '0;
  logic [CntW-1:0] num_words_i = '0;
  logic [31:0]     seed_i = '0;
  logic            busy_o, done_o, pass_o;
  logic [CntW-1:0] err_cnt_o;
  logic [31:0]     first_err_addr_o;
  logic            tcdm_req_o, tcdm_wen_o;
  logic [31:0]     tcdm_add_o, tcdm_wdata_o;
  logic [3:0]      tcdm_be_o;
  logic            tcdm_gnt_i;
  logic            tcdm_r_valid_i = 1'b0;
  logic [31:0]     tcdm_r_rdata_i = '0;
  logic            tcdm_r_opc_i = 1'b0;
  logic            gnt_en = 1'b1;

  assign tcdm_gnt_i = tcdm_req_o & gnt_en;

  always #5 clk_i = ~clk_i;

  tcdm_fill_check #(
    .MAX_OUTSTANDING(MaxOut),
    .CNT_WIDTH      (CntW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .base_addr_i     (base_addr_i),
    .num_words_i     (num_words_i),
    .seed_i          (seed_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .pass_o          (pass_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_addr_o(first_err_addr_o),
    .tcdm_req_o      (tcdm_req_o),
    .tcdm_add_o      (tcdm_add_o),
    .tcdm_wen_o      (tcdm_wen_o),
    .tcdm_wdata_o    (tcdm_wdata_o),
    .tcdm_be_o       (tcdm_be_o),
    .tcdm_gnt_i      (tcdm_gnt_i),
    .tcdm_r_valid_i  (tcdm_r_valid_i),
    .tcdm_r_rdata_i  (tcdm_r_rdata_i),
    .tcdm_r_opc_i    (tcdm_r_opc_i)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic        pass;
    logic [31:0] err;
    logic [31:0] first;
  } done_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  done_t       exp_done[$];
  logic [31:0] mem[logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int n_req = 0;

  // Slave configuration, set by the stimulus while the DUT is idle.
  int corrupt_idx = -1;
  bit opc_all = 1'b0;
  bit stall_mode = 1'b0;
  bit chk_rate = 1'b0;
  int rd_idx = 0;
  int wr_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: combinational gnt gated by stalls, response one cycle after grant.
  // Also the request-side monitor of the scoreboard.
  initial begin : slave
    logic        pend_v, pend_o, hold_valid, hold_wen;
    logic [31:0] pend_d, hold_add, hold_wdata;
    int          outst, stall_left, last_wr_cyc;
    wr_t         w;
    logic [31:0] ra;
    pend_v = 0; pend_o = 0; pend_d = '0; hold_valid = 0; hold_wen = 0;
    hold_add = '0; hold_wdata = '0; outst = 0; stall_left = 0; last_wr_cyc = 0;
    forever begin
      @(negedge clk_i);
      tcdm_r_valid_i = pend_v;
      tcdm_r_rdata_i = pend_d;
      tcdm_r_opc_i   = pend_o;
      if (pend_v) outst--;
      pend_v = 0;
      if (!rst_ni) begin
        hold_valid = 0;
        outst      = 0;
        stall_left = 0;
        gnt_en     = 1'b1;
        continue;
      end
      if (stall_mode && stall_left > 0) begin
        gnt_en = 1'b0;
        stall_left--;
      end else begin
        gnt_en = 1'b1;
      end
      if (tcdm_req_o) begin
        n_req++;
        if (hold_valid) begin
          check("stable_add", tcdm_add_o, hold_add);
          check("stable_wen", 32'(tcdm_wen_o), 32'(hold_wen));
          check("stable_wdata", tcdm_wdata_o, hold_wdata);
        end
        if (gnt_en) begin
          hold_valid = 0;
          outst++;
          check("outstanding_le_max", 32'(outst <= int'(MaxOut)), 32'd1);
          check("be", 32'(tcdm_be_o), 32'hF);
          if (!tcdm_wen_o) begin
            if (exp_wr.size() == 0) begin
              check("unexpected_write", tcdm_add_o, 32'hFFFF_FFFF);
            end else begin
              w = exp_wr.pop_front();
              check("wr_addr", tcdm_add_o, w.a);
              check("wr_data", tcdm_wdata_o, w.d);
            end
            if (chk_rate && wr_seen > 0) check("issue_rate", 32'(cyc - last_wr_cyc), 32'd1);
            last_wr_cyc = cyc;
            wr_seen++;
            mem[tcdm_add_o] = tcdm_wdata_o;
            pend_d = '0;
            pend_o = 1'b0;
          end else begin
            if (exp_rd.size() == 0) begin
              check("unexpected_read", tcdm_add_o, 32'hFFFF_FFFF);
            end else begin
              ra = exp_rd.pop_front();
              check("rd_addr", tcdm_add_o, ra);
            end
            pend_d = mem.exists(tcdm_add_o) ? mem[tcdm_add_o] : 32'hDEAD_0000;
            if (rd_idx == corrupt_idx) pend_d = pend_d ^ 32'h1;
            pend_o = opc_all;
            rd_idx++;
          end
          pend_v = 1'b1;
          if (stall_mode) stall_left = $urandom_range(0, 3);
        end else begin
          hold_valid = 1;
          hold_add   = tcdm_add_o;
          hold_wen   = tcdm_wen_o;
          hold_wdata = tcdm_wdata_o;
        end
      end else begin
        if (hold_valid) check("req_dropped_before_gnt", 32'(tcdm_req_o), 32'd1);
        hold_valid = 0;
      end
    end
  end

  // Completion monitor: pops the expected result whenever done_o pulses.
  initial begin : done_mon
    done_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          check("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          e = exp_done.pop_front();
          check("pass", 32'(pass_o), 32'(e.pass));
          check("err_cnt", 32'(err_cnt_o), e.err);
          check("first_err_addr", first_err_addr_o, e.first);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] base, input int num, input logic [31:0] seed);
    logic [31:0] a;
    for (int k = 0; k < num; k++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * k);
      exp_wr.push_back('{a: a, d: a ^ seed});
      exp_rd.push_back(a);
    end
  endtask

  task automatic run(input string name, input logic [31:0] base, input int num,
                     input logic [31:0] seed, input int corrupt, input bit opc, input bit stall,
                     input bit rate, input bit dup, input bit e_pass, input int e_err,
                     input logic [31:0] e_first);
    int target, start_cyc, req0, w;
    push_exp(base, num, seed);
    exp_done.push_back('{pass: e_pass, err: 32'(e_err), first: e_first});
    corrupt_idx = corrupt;
    opc_all     = opc;
    stall_mode  = stall;
    chk_rate    = rate;
    rd_idx      = 0;
    wr_seen     = 0;
    target      = done_cnt + 1;
    req0        = n_req;
    @(negedge clk_i);
    base_addr_i = base;
    num_words_i = CntW'(num);
    seed_i      = seed;
    start_i     = 1'b1;
    start_cyc   = cyc;
    @(negedge clk_i);
    check({name, "_busy_after_start"}, 32'(busy_o), 32'd1);
    if (dup) begin
      // Second strobe lands while the engine is already writing.
      base_addr_i = 32'h1C04_0000;
      num_words_i = CntW'(1);
      seed_i      = 32'h0;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    w = 0;
    while (done_cnt < target && w < 2000) begin
      @(negedge clk_i);
      w++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done_o, required done_o within 2000 cycles", name);
    end
    if (num == 0) begin
      check({name, "_done_latency_le2"}, 32'((done_cyc - start_cyc) <= 2), 32'd1);
      check({name, "_no_req"}, 32'(n_req - req0), 32'd0);
    end
    repeat (2) @(negedge clk_i);
    check({name, "_busy_end"}, 32'(busy_o), 32'd0);
    check({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
  endtask

  initial begin : stim
    int w;
    repeat (2) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_req", 32'(tcdm_req_o), 32'd0);
    check("rst_wen", 32'(tcdm_wen_o), 32'd1);
    check("rst_err", 32'(err_cnt_o), 32'd0);
    check("rst_first", first_err_addr_o, 32'd0);
    check("rst_add", tcdm_add_o, 32'd0);
    check("rst_wdata", tcdm_wdata_o, 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    run("basic", 32'h1C01_0000, 4, 32'hA5A5_A5A5, -1, 0, 0, 1, 0, 1'b1, 0, 32'h0);
    run("corrupt", 32'h1C01_0000, 4, 32'hA5A5_A5A5, 2, 0, 0, 0, 0, 1'b0, 1, 32'h1C01_0008);
    run("stall", 32'h1C02_0000, 16, 32'h0F0F_1234, -1, 0, 1, 0, 0, 1'b1, 0, 32'h0);
    run("zero", 32'h1C05_0000, 0, 32'h1111_1111, -1, 0, 0, 0, 0, 1'b1, 0, 32'h0);
    run("opc", 32'h1C06_0000, 3, 32'h5A5A_0000, -1, 1, 0, 0, 0, 1'b0, 3, 32'h1C06_0000);
    run("wrap", 32'hFFFF_FFFB, 4, 32'h1234_5678, -1, 0, 0, 0, 0, 1'b1, 0, 32'h0);

    // Reset in the middle of the read phase.
    push_exp(32'h1C07_0000, 8, 32'h0BAD_CAFE);
    corrupt_idx = -1; opc_all = 0; stall_mode = 1; chk_rate = 0; rd_idx = 0;
    @(negedge clk_i);
    base_addr_i = 32'h1C07_0000;
    num_words_i = CntW'(8);
    seed_i      = 32'h0BAD_CAFE;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    w = 0;
    while (!(tcdm_req_o && tcdm_wen_o) && w < 300) begin
      @(negedge clk_i);
      w++;
    end
    check("reached_read_phase", 32'(tcdm_req_o && tcdm_wen_o), 32'd1);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_req", 32'(tcdm_req_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_wen", 32'(tcdm_wen_o), 32'd1);
    check("midrst_add", tcdm_add_o, 32'd0);
    check("midrst_err", 32'(err_cnt_o), 32'd0);
    @(negedge clk_i);
    exp_wr.delete();
    exp_rd.delete();
    stall_mode = 0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    run("after_rst_dup_start", 32'h1C03_0000, 5, 32'hDEAD_BEEF, -1, 0, 0, 1, 1, 1'b1, 0, 32'h0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/tcdm_fill_check.md
Name: tcdm_fill_check

Overview:
- TCDM initiator that drives one XBAR_TCDM_BUS slave port of the SoC L2 (interleaved or private bank).
- Fills a contiguous word range with an address-derived pattern, reads the range back, and compares every response.
- Used for boot-time L2 scrub/initialisation and for production memory test.
- Handles the full gnt/r_valid handshake, so it works with fixed-latency and stalling slaves.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted requests awaiting r_valid (>=1).
- CNT_WIDTH, 16, width of the word count and error counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle start strobe; ignored while busy_o=1
- base_addr_i  in  32  first byte address; bits [1:0] forced to 0
- num_words_i  in  CNT_WIDTH  words to fill and check
- seed_i  in  32  pattern seed
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse at completion
- pass_o  out  1  last run had zero errors; valid from done_o until next start
- err_cnt_o  out  CNT_WIDTH  mismatches in last run, saturating
- first_err_addr_o  out  32  byte address of first mismatch
- tcdm_req_o  out  1  request
- tcdm_add_o  out  32  byte address
- tcdm_wen_o  out  1  1=read, 0=write
- tcdm_wdata_o  out  32  write data
- tcdm_be_o  out  4  byte enables, always 4'hF
- tcdm_gnt_i  in  1  grant
- tcdm_r_valid_i  in  1  response valid; issued for reads and writes
- tcdm_r_rdata_i  in  32  read data
- tcdm_r_opc_i  in  1  response error flag

Behaviour:
- Reset values:
  - busy_o, done_o, pass_o, tcdm_req_o = 0; tcdm_wen_o = 1.
  - err_cnt_o, first_err_addr_o, tcdm_add_o, tcdm_wdata_o = 0.
  - State = IDLE; all counters = 0.
- Pattern: word k has address A = base + 4k and data D(k) = A ^ seed_i. base_addr_i and seed_i are captured at start.
- FSM states: IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE.
  - IDLE: on start_i with num_words_i=0, go to DONE (no bus activity). On start_i with num_words_i>0, capture inputs, clear err_cnt/first_err_addr/pass, go to WRITE. busy_o=1 in every state except IDLE.
  - WRITE: assert req with wen=0 and add/wdata for the current issue index. The index advances only on req&gnt. Go to WDRAIN after the last word is granted.
  - WDRAIN: no req; wait until outstanding=0, then go to READ with issue index reset.
  - READ: assert req with wen=1, same address sequence. Go to RDRAIN after the last word is granted.
  - RDRAIN: no req; wait until every read response has arrived, then go to DONE.
  - DONE: pulse done_o for one cycle; pass_o = (err_cnt=0); go to IDLE.
- Request stability: while req=1 and gnt=0, add, wen and wdata are held stable. req is not dropped until granted.
- Outstanding counter:
  - +1 on req&gnt, -1 on r_valid; both in the same cycle leaves it unchanged.
  - req is deasserted while outstanding=MAX_OUTSTANDING.
  - A grant and a response in the same cycle are legal, so back-to-back issue at 1-cycle latency runs at 1 word/cycle.
- Read check:
  - Responses are in order. A response index counter increments on each r_valid in READ/RDRAIN; expected value = D(rsp_idx).
  - Mismatch or r_opc=1 increments err_cnt (saturating at all-ones).
  - On the first error only, first_err_addr = base + 4*rsp_idx.
  - Write responses are counted for drain only and are never checked.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error.
- start_i while busy: ignored; no state change.
- Reset mid-operation: every output returns to its reset value immediately, and req drops asynchronously. Outstanding bus responses are not tracked after reset.

Decomposition:
- Package tcdm_fill_check_pkg holds:
  - the state enum typedef;
  - the pattern function (addr, seed) -> data;
  - the constant BE_ALL = 4'hF.
- One sub-module, tcdm_outstanding_cnt: up/down counter with full/empty flags, parameterised by MAX_OUTSTANDING.

Test Plan:
- 1-cycle slave (gnt=req, r_valid one cycle later), base=0x1C01_0000, num=4, seed=0xA5A5_A5A5:
  - writes go to 0x1C01_0000..0x1C01_000C with data addr^seed;
  - issue rate is 1 word/cycle;
  - done_o pulses with pass_o=1 and err_cnt_o=0.
- Same setup, slave corrupts the read of word 2 (XOR 0x1) -> err_cnt_o=1, first_err_addr_o=0x1C01_0008, pass_o=0.
- Random gnt stalls (gnt low 0-3 cycles) and MAX_OUTSTANDING=2:
  - add/wdata stay stable while gnt=0;
  - outstanding never exceeds 2;
  - num=16 completes with pass_o=1.
- num_words=0 -> no tcdm_req_o ever asserted; done_o pulses within 2 cycles of start_i; pass_o=1.
- Responses with r_opc=1 on every read, num=3 -> err_cnt_o=3.
- Reset edge cases:
  - rst_ni low during READ -> tcdm_req_o=0 and busy_o=0 immediately;
  - a fresh start afterwards runs cleanly;
  - start_i asserted during WRITE is ignored.
